// File: rtl/riscv_enc_pkg.sv
// riscv_enc_pkg: shared types for the RV32I instruction encoder.
//   - opcode constants for the supported major opcodes
//   - fmt_e: instruction format selector (ILL for unsupported opcodes)
//   - enc_fields_t: decoded field bundle presented to the encoder
//   - fmt_of_op(): opcode -> format lookup
package riscv_enc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_S   = 3'b001,
    FMT_B   = 3'b010,
    FMT_J   = 3'b011,
    FMT_U   = 3'b100,
    FMT_R   = 3'b101,
    FMT_ILL = 3'b111
  } fmt_e;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_fields_t;

  function automatic fmt_e fmt_of_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: return FMT_I;
      OP_STORE:                 return FMT_S;
      OP_BRANCH:                return FMT_B;
      OP_JAL:                   return FMT_J;
      OP_AUIPC, OP_LUI:         return FMT_U;
      OP_OP:                    return FMT_R;
      default:                  return FMT_ILL;
    endcase
  endfunction

endpackage

// File: rtl/imm_packer.sv
// imm_packer: combinational instruction packer.
//   fmt      in  format selected from the opcode
//   f        in  decoded field bundle
//   word     out packed 32-bit instruction word
//   range_ok out immediate fits the format (always 0 for FMT_ILL)
module imm_packer
  import riscv_enc_pkg::*;
(
  input  fmt_e        fmt,
  input  enc_fields_t f,
  output logic [31:0] word,
  output logic        range_ok
);

  // Immediate is a sign extension of its low bits when the upper slice is uniform.
  logic sx11, sx12, sx20;
  assign sx11 = (&f.imm[31:11]) | ~(|f.imm[31:11]);
  assign sx12 = (&f.imm[31:12]) | ~(|f.imm[31:12]);
  assign sx20 = (&f.imm[31:20]) | ~(|f.imm[31:20]);

  always_comb begin
    word     = '0;
    range_ok = 1'b0;
    case (fmt)
      FMT_I: begin
        word     = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.op};
        range_ok = sx11;
      end
      FMT_S: begin
        word     = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.op};
        range_ok = sx11;
      end
      FMT_B: begin
        word     = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                    f.imm[4:1], f.imm[11], f.op};
        range_ok = sx12 & ~f.imm[0];
      end
      FMT_J: begin
        word     = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.op};
        range_ok = sx20 & ~f.imm[0];
      end
      FMT_U: begin
        word     = {f.imm[31:12], f.rd, f.op};
        range_ok = ~(|f.imm[11:0]);
      end
      FMT_R: begin
        word     = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.op};
        range_ok = 1'b1;
      end
      default: begin
        word     = '0;
        range_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I field bundles into instruction words and
// streams them into instruction memory at sequential word addresses.
//   clk, reset               clock, async active-high reset
//   in_valid/in_ready        field bundle handshake
//   op..imm                  decoded fields
//   addr_clr                 return write pointer/count to initial values
//   mem_we/mem_ready         write strobe (output valid) / memory accept
//   mem_addr/mem_wdata       write byte address / encoded word
//   words_written            saturating completed-write count
//   err/err_op               sticky reject flag / opcode of last reject
module instr_encoder
  import riscv_enc_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              addr_clr,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [15:0]       words_written,
  output logic              err,
  output logic [6:0]        err_op
);

  enc_fields_t f;
  logic [31:0] word;
  logic        range_ok;

  assign f = '{op: op, rd: rd, rs1: rs1, rs2: rs2, funct3: funct3,
               funct7: funct7, imm: imm};

  imm_packer u_pack (
    .fmt      (fmt_of_op(op)),
    .f        (f),
    .word     (word),
    .range_ok (range_ok)
  );

  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       words_q, words_d;
  logic              err_q, err_d;
  logic [6:0]        err_op_q, err_op_d;

  logic accept, take, reject, complete;

  assign in_ready = !mem_we_q || mem_ready;
  assign accept   = in_valid && in_ready;
  assign take     = accept && range_ok;   // ILL formats never report range_ok
  assign reject   = accept && !range_ok;
  assign complete = mem_we_q && mem_ready;

  always_comb begin
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    mem_addr_d  = mem_addr_q;
    words_d     = words_q;
    err_d       = err_q;
    err_op_d    = err_op_q;

    if (take) begin
      mem_we_d    = 1'b1;
      mem_wdata_d = word;
    end else if (complete) begin
      mem_we_d = 1'b0;
    end

    if (complete) begin
      mem_addr_d = mem_addr_q + ADDR_W'(4);
      words_d    = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;
    end

    // Clear wins over a same-cycle completion; the pending word itself stays.
    if (addr_clr) begin
      mem_addr_d = BASE_ADDR;
      words_d    = '0;
    end

    if (reject) begin
      err_d    = 1'b1;
      err_op_d = op;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_addr_q  <= BASE_ADDR;
      words_q     <= '0;
      err_q       <= 1'b0;
      err_op_q    <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_addr_q  <= mem_addr_d;
      words_q     <= words_d;
      err_q       <= err_d;
      err_op_q    <= err_op_d;
    end
  end

  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_addr      = mem_addr_q;
  assign words_written = words_q;
  assign err           = err_q;
  assign err_op        = err_op_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vector table for packing/range checks plus
// hand sequences for stall, addr_clr, reset and address wrap.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (ADDR_W=32, BASE_ADDR=0)
  logic        reset, in_valid, in_ready, addr_clr, mem_we, mem_ready, err;
  logic [6:0]  op, funct7, err_op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm, mem_addr, mem_wdata;
  logic [15:0] words_written;

  instr_encoder u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .addr_clr(addr_clr), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .words_written(words_written),
    .err(err), .err_op(err_op)
  );

  // wrap instance (ADDR_W=4, BASE_ADDR=0xC)
  logic        b_reset, b_in_valid, b_in_ready, b_addr_clr, b_mem_we, b_mem_ready, b_err;
  logic [6:0]  b_op, b_funct7, b_err_op;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_funct3;
  logic [31:0] b_imm, b_mem_wdata;
  logic [3:0]  b_mem_addr;
  logic [15:0] b_words_written;

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) u_wrap (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .op(b_op), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .funct3(b_funct3),
    .funct7(b_funct7), .imm(b_imm), .addr_clr(b_addr_clr), .mem_we(b_mem_we),
    .mem_ready(b_mem_ready), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .words_written(b_words_written), .err(b_err), .err_op(b_err_op)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ok;
    logic [31:0] word;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] i, input logic k, input logic [31:0] w);
    vec_t v;
    v.op = o; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = f3; v.f7 = f7;
    v.imm = i; v.ok = k; v.word = w;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = 1'b1; op = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  vec_t tv[21];
  logic [31:0] exp_addr;
  logic [15:0] exp_words;
  logic        exp_err;
  logic [6:0]  exp_err_op;
  vec_t        addi7, addi8;

  initial begin
    tv[0]  = mk(7'h13, 1, 0, 0, 0, 0,    32'd5,         1, 32'h00500093);
    tv[1]  = mk(7'h23, 0, 1, 5, 2, 0,    32'd4,         1, 32'h0050A223);
    tv[2]  = mk(7'h63, 0, 0, 0, 0, 0,    -32'sd4,       1, 32'hFE000EE3);
    tv[3]  = mk(7'h6F, 1, 0, 0, 0, 0,    32'd8,         1, 32'h008000EF);
    tv[4]  = mk(7'h37, 2, 0, 0, 0, 0,    32'h12345000,  1, 32'h12345137);
    tv[5]  = mk(7'h33, 3, 1, 2, 0, 0,    32'd0,         1, 32'h002081B3);
    tv[6]  = mk(7'h13, 1, 0, 0, 0, 0,    32'd4096,      0, 32'h0);
    tv[7]  = mk(7'h63, 0, 0, 0, 0, 0,    32'd3,         0, 32'h0);
    tv[8]  = mk(7'h13, 1, 0, 0, 0, 0,    -32'sd2048,    1, 32'h80000093);
    tv[9]  = mk(7'h13, 2, 3, 0, 0, 0,    32'd2047,      1, 32'h7FF18113);
    tv[10] = mk(7'h63, 0, 0, 0, 0, 0,    32'd4094,      1, 32'h7E000FE3);
    tv[11] = mk(7'h63, 0, 0, 0, 0, 0,    -32'sd4096,    1, 32'h80000063);
    tv[12] = mk(7'h6F, 0, 0, 0, 0, 0,    -32'sd2,       1, 32'hFFFFF06F);
    tv[13] = mk(7'h6F, 0, 0, 0, 0, 0,    32'h00100000,  0, 32'h0);
    tv[14] = mk(7'h33, 5, 6, 7, 0, 7'h20, 32'hDEADBEEF, 1, 32'h407302B3);
    tv[15] = mk(7'h17, 4, 0, 0, 0, 0,    32'hFFFFF000,  1, 32'hFFFFF217);
    tv[16] = mk(7'h37, 0, 0, 0, 0, 0,    32'h00001001,  0, 32'h0);
    tv[17] = mk(7'h23, 0, 1, 5, 2, 0,    -32'sd2049,    0, 32'h0);
    tv[18] = mk(7'h03, 6, 2, 0, 2, 0,    32'hFFFFFFFF,  1, 32'hFFF12303);
    tv[19] = mk(7'h67, 0, 1, 0, 0, 0,    32'd0,         1, 32'h00008067);
    tv[20] = mk(7'h7F, 0, 0, 0, 0, 0,    32'd0,         0, 32'h0);
    addi7  = mk(7'h13, 7, 0, 0, 0, 0,    32'd1,         1, 32'h00100393);
    addi8  = mk(7'h13, 8, 0, 0, 0, 0,    32'd1,         1, 32'h00100413);

    reset = 1'b1; in_valid = 0; op = 0; rd = 0; rs1 = 0; rs2 = 0; funct3 = 0;
    funct7 = 0; imm = 0; addr_clr = 0; mem_ready = 1'b1;
    b_reset = 1'b1; b_in_valid = 0; b_op = 0; b_rd = 0; b_rs1 = 0; b_rs2 = 0;
    b_funct3 = 0; b_funct7 = 0; b_imm = 0; b_addr_clr = 0; b_mem_ready = 1'b1;
    step(); step();
    reset = 1'b0; b_reset = 1'b0;

    // reset state
    chk("rst_we",    {31'b0, mem_we}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_words", {16'b0, words_written}, 32'd0);
    chk("rst_err",   {31'b0, err}, 32'd0);
    chk("rst_errop", {25'b0, err_op}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_waddr", {28'b0, b_mem_addr}, 32'hC);

    // table: back-to-back with mem_ready=1
    exp_addr = 0; exp_words = 0; exp_err = 0; exp_err_op = 0;
    for (int i = 0; i < 21; i++) begin
      drive(tv[i]);
      step();
      if (tv[i].ok) begin
        chk($sformatf("v%0d_we", i),    {31'b0, mem_we}, 32'd1);
        chk($sformatf("v%0d_word", i),  mem_wdata, tv[i].word);
        chk($sformatf("v%0d_addr", i),  mem_addr, exp_addr);
        exp_addr += 4;
        exp_words++;
      end else begin
        chk($sformatf("v%0d_we", i),    {31'b0, mem_we}, 32'd0);
        chk($sformatf("v%0d_addr", i),  mem_addr, exp_addr);
        exp_err = 1'b1;
        exp_err_op = tv[i].op;
      end
      chk($sformatf("v%0d_err", i),   {31'b0, err}, {31'b0, exp_err});
      chk($sformatf("v%0d_errop", i), {25'b0, err_op}, {25'b0, exp_err_op});
    end
    in_valid = 1'b0;
    step();
    chk("tbl_words", {16'b0, words_written}, {16'b0, exp_words});
    chk("tbl_addr",  mem_addr, exp_addr);
    chk("tbl_we",    {31'b0, mem_we}, 32'd0);

    // stall: mem_ready low for 3 cycles with a pending write
    mem_ready = 1'b0;
    drive(addi7);
    step();
    drive(addi8);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("st%0d_ready", c), {31'b0, in_ready}, 32'd0);
      chk($sformatf("st%0d_we", c),    {31'b0, mem_we}, 32'd1);
      chk($sformatf("st%0d_word", c),  mem_wdata, 32'h00100393);
      chk($sformatf("st%0d_addr", c),  mem_addr, exp_addr);
      step();
    end
    in_valid = 1'b0; mem_ready = 1'b1;
    step();
    exp_addr += 4; exp_words++;
    chk("st_rel_we",    {31'b0, mem_we}, 32'd0);
    chk("st_rel_words", {16'b0, words_written}, {16'b0, exp_words});
    chk("st_rel_addr",  mem_addr, exp_addr);
    step();
    chk("st_nodup",     {16'b0, words_written}, {16'b0, exp_words});

    // addr_clr colliding with a completing write
    mem_ready = 1'b0;
    drive(addi7);
    step();
    in_valid = 1'b0;
    chk("clr_pend_we", {31'b0, mem_we}, 32'd1);
    mem_ready = 1'b1; addr_clr = 1'b1;
    step();
    addr_clr = 1'b0;
    chk("clr_addr",  mem_addr, 32'd0);
    chk("clr_words", {16'b0, words_written}, 32'd0);
    chk("clr_we",    {31'b0, mem_we}, 32'd0);
    chk("clr_err",   {31'b0, err}, 32'd1);

    // async reset with a pending write
    mem_ready = 1'b0;
    drive(addi8);
    step();
    in_valid = 1'b0;
    chk("ar_pend_we", {31'b0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    chk("ar_we",    {31'b0, mem_we}, 32'd0);
    chk("ar_wdata", mem_wdata, 32'd0);
    chk("ar_addr",  mem_addr, 32'd0);
    chk("ar_err",   {31'b0, err}, 32'd0);
    chk("ar_errop", {25'b0, err_op}, 32'd0);
    step();
    reset = 1'b0; mem_ready = 1'b1;

    // address wrap on the 4-bit instance
    b_in_valid = 1'b1; b_op = 7'h13; b_rd = 5'd1; b_imm = 32'd1;
    step();
    chk("wr0_we",   {31'b0, b_mem_we}, 32'd1);
    chk("wr0_addr", {28'b0, b_mem_addr}, 32'hC);
    b_rd = 5'd2;
    step();
    b_in_valid = 1'b0;
    chk("wr1_addr", {28'b0, b_mem_addr}, 32'h0);
    chk("wr1_word", b_mem_wdata, 32'h00100113);
    step();
    chk("wr_words", {16'b0, b_words_written}, 32'd2);
    chk("wr_addr",  {28'b0, b_mem_addr}, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
